// File: rtl/fx_pkg.sv
// Shared types and constants for the fixed-point writeback/completion stage.
package fx_pkg;

  // Functional unit codes as driven on functionalUnitCode_i
  localparam logic [2:0] UnitFx = 3'd0;
  localparam logic [2:0] UnitLs = 3'd1;
  localparam logic [2:0] UnitBr = 3'd2;
  localparam logic [2:0] UnitFp = 3'd3;

  // Bit positions inside the 4-bit CR0 field {LT,GT,EQ,SO}
  localparam int Cr0Lt = 3;
  localparam int Cr0Gt = 2;
  localparam int Cr0Eq = 1;
  localparam int Cr0So = 0;

  typedef struct packed {
    logic        wr_en;
    logic        cr_en;
    logic        ca_en;
    logic        ca;
    logic        ca32;
    logic        is64;
    logic [63:0] value;
  } fx_entry_t;

  function automatic logic [3:0] cr0_compare(input logic [63:0] value, input logic is64,
                                             input logic so);
    logic       neg;
    logic       zero;
    logic [3:0] cr;
    neg  = is64 ? value[63] : value[31];
    zero = is64 ? (value == 64'd0) : (value[31:0] == 32'd0);
    cr = 4'd0;
    cr[Cr0Lt] = neg;
    cr[Cr0Gt] = !neg && !zero;
    cr[Cr0Eq] = zero;
    cr[Cr0So] = so;
    return cr;
  endfunction

endpackage

// File: rtl/fx_writeback_if.sv
// Signal bundle between the FX unit, the shared GPR write port and the writeback stage.
interface fx_writeback_if #(
  parameter int regWidth = 5
);
  logic                enable_i;
  logic [2:0]          functionalUnitCode_i;
  logic                is64Bit_i;
  logic                reg1WritebackEnable_i;
  logic [regWidth-1:0] reg1WritebackAddress_i;
  logic [63:0]         reg1WritebackVal_i;
  logic                reg2WritebackEnable_i;
  logic                caUpdate_i;
  logic [63:0]         reg2WritebackVal_i;
  logic                regFileReady_i;
  logic                regFileWriteEnable_o;
  logic [regWidth-1:0] regFileWriteAddress_o;
  logic [63:0]         regFileWriteVal_o;
  logic                crWriteEnable_o;
  logic [3:0]          cr0_o;
  logic                xerCA_o;
  logic                xerCA32_o;
  logic                xerSO_o;
  logic                stall_o;
  logic                overflow_o;

  modport master (
    output enable_i, functionalUnitCode_i, is64Bit_i, reg1WritebackEnable_i,
           reg1WritebackAddress_i, reg1WritebackVal_i, reg2WritebackEnable_i, caUpdate_i,
           reg2WritebackVal_i, regFileReady_i,
    input  regFileWriteEnable_o, regFileWriteAddress_o, regFileWriteVal_o, crWriteEnable_o,
           cr0_o, xerCA_o, xerCA32_o, xerSO_o, stall_o, overflow_o
  );

  modport slave (
    input  enable_i, functionalUnitCode_i, is64Bit_i, reg1WritebackEnable_i,
           reg1WritebackAddress_i, reg1WritebackVal_i, reg2WritebackEnable_i, caUpdate_i,
           reg2WritebackVal_i, regFileReady_i,
    output regFileWriteEnable_o, regFileWriteAddress_o, regFileWriteVal_o, crWriteEnable_o,
           cr0_o, xerCA_o, xerCA32_o, xerSO_o, stall_o, overflow_o
  );
endinterface

// File: rtl/fx_wb_fifo.sv
// Small in-order synchronous FIFO with show-ahead head data; pushes while full are dropped.
module fx_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        data_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PtrW-1:0]  wr_ptr_reg;
  logic [PtrW-1:0]  rd_ptr_reg;
  logic [CntW-1:0]  count_reg;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_reg == CntW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_reg[rd_ptr_reg];
  assign count_o = count_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clock_i) begin
      if (do_push && (wr_ptr_reg == PtrW'(gi))) begin
        mem_reg[gi] <= data_i;
      end
    end
  end

  // Depth is a power of two, so the pointers wrap naturally
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fx_writeback.sv
// FX writeback/completion: queues FX results in order, drains them to the GPR port
// under a ready handshake, and updates CR0 and XER CA/CA32 as each entry retires.
module fx_writeback
  import fx_pkg::*;
#(
  parameter int         regWidth   = 5,
  parameter int         depth      = 4,
  parameter logic [2:0] FXUnitCode = UnitFx
) (
  input logic           clock_i,
  input logic           reset_i,
  fx_writeback_if.slave bus
);
  localparam int CntW = $clog2(depth) + 1;
  localparam int EntW = $bits(fx_entry_t) + regWidth;

  fx_entry_t           in_entry;
  fx_entry_t           head_entry;
  logic [regWidth-1:0] head_addr;
  logic [EntW-1:0]     fifo_wdata;
  logic [EntW-1:0]     fifo_rdata;
  logic [CntW-1:0]     fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept;
  logic                retire;
  logic [3:0]          cr0_next;

  logic                wr_en_reg;
  logic [regWidth-1:0] wr_addr_reg;
  logic [63:0]         wr_val_reg;
  logic                cr_en_reg;
  logic [3:0]          cr0_reg;
  logic                xer_ca_reg;
  logic                xer_ca32_reg;
  logic                xer_so_reg;
  logic                overflow_reg;
  logic                unused_reg2_bits;

  assign accept = reset_i && bus.enable_i && (bus.functionalUnitCode_i == FXUnitCode) &&
                  (bus.reg1WritebackEnable_i || bus.reg2WritebackEnable_i || bus.caUpdate_i);

  always_comb begin
    in_entry       = '0;
    in_entry.wr_en = bus.reg1WritebackEnable_i;
    in_entry.cr_en = bus.reg2WritebackEnable_i;
    in_entry.ca_en = bus.caUpdate_i;
    in_entry.ca    = bus.reg2WritebackVal_i[0];
    in_entry.ca32  = bus.reg2WritebackVal_i[1];
    in_entry.is64  = bus.is64Bit_i;
    in_entry.value = bus.reg1WritebackVal_i;
  end

  assign unused_reg2_bits = ^bus.reg2WritebackVal_i[63:2];
  assign fifo_wdata = {bus.reg1WritebackAddress_i, in_entry};
  assign {head_addr, head_entry} = fifo_rdata;

  // A head that does not write a GPR never waits for the register-file port
  assign retire   = !fifo_empty && (!head_entry.wr_en || bus.regFileReady_i);
  assign cr0_next = cr0_compare(head_entry.value, head_entry.is64, xer_so_reg);

  fx_wb_fifo #(
    .WIDTH(EntW),
    .DEPTH(depth)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (accept),
    .pop_i   (retire),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_val_reg   <= '0;
      cr_en_reg    <= 1'b0;
      cr0_reg      <= '0;
      xer_ca_reg   <= 1'b0;
      xer_ca32_reg <= 1'b0;
      xer_so_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_en_reg <= retire && head_entry.wr_en;
      cr_en_reg <= retire && head_entry.cr_en;
      if (retire && head_entry.wr_en) begin
        wr_addr_reg <= head_addr;
        wr_val_reg  <= head_entry.value;
      end
      if (retire && head_entry.cr_en) cr0_reg <= cr0_next;
      if (retire && head_entry.ca_en) begin
        xer_ca_reg   <= head_entry.ca;
        xer_ca32_reg <= head_entry.ca32;
      end
      // Full is judged before this edge's retire, so a same-cycle pop does not rescue the push
      if (accept && fifo_full) overflow_reg <= 1'b1;
    end
  end

  assign bus.regFileWriteEnable_o  = wr_en_reg;
  assign bus.regFileWriteAddress_o = wr_addr_reg;
  assign bus.regFileWriteVal_o     = wr_val_reg;
  assign bus.crWriteEnable_o       = cr_en_reg;
  assign bus.cr0_o                 = cr0_reg;
  assign bus.xerCA_o               = xer_ca_reg;
  assign bus.xerCA32_o             = xer_ca32_reg;
  assign bus.xerSO_o               = xer_so_reg;
  assign bus.stall_o               = (fifo_count == CntW'(depth));
  assign bus.overflow_o            = overflow_reg;
endmodule

// File: tb/tb_fx_writeback.sv
// Bench for fx_writeback: table of single-entry vectors plus hand-written multi-cycle sequences.
module tb_fx_writeback;
  logic clock_i;
  logic reset_i;
  int   tests_run = 0;
  int   fails = 0;

  fx_writeback_if #(.regWidth(5)) bus ();

  fx_writeback #(
    .regWidth(5),
    .depth(4),
    .FXUnitCode(3'd0)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] val;
  } gpr_exp_t;

  gpr_exp_t   gq[$];
  logic [3:0] cq[$];

  typedef struct {
    logic        en;
    logic [2:0]  unit;
    logic        is64;
    logic        wr;
    logic [4:0]  addr;
    logic [63:0] val;
    logic        cr;
    logic        ca;
    logic [1:0]  carry;
    logic [3:0]  exp_cr0;
    logic        exp_ca;
    logic        exp_ca32;
    logic        acc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation
  task automatic monitor();
    gpr_exp_t e;
    logic [3:0] c;
    if (bus.regFileWriteEnable_o === 1'b1) begin
      if (gq.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL gpr_unexpected: got write r%0d=0x%0h, expected none",
                 bus.regFileWriteAddress_o, bus.regFileWriteVal_o);
      end else begin
        e = gq.pop_front();
        check("gpr_addr", 64'(bus.regFileWriteAddress_o), 64'(e.addr));
        check("gpr_val", bus.regFileWriteVal_o, e.val);
        $display("[TB] gpr write r%0d = 0x%0h", bus.regFileWriteAddress_o, bus.regFileWriteVal_o);
      end
    end
    if (bus.crWriteEnable_o === 1'b1) begin
      if (cq.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL cr_unexpected: got cr0 write %b, expected none", bus.cr0_o);
      end else begin
        c = cq.pop_front();
        check("cr0_write", 64'(bus.cr0_o), 64'(c));
        $display("[TB] cr0 write %b", bus.cr0_o);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock_i);
    monitor();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] unit, input logic is64, input logic wr,
                       input logic [4:0] addr, input logic [63:0] val, input logic cr,
                       input logic ca, input logic [1:0] carry);
    bus.enable_i               = en;
    bus.functionalUnitCode_i   = unit;
    bus.is64Bit_i              = is64;
    bus.reg1WritebackEnable_i  = wr;
    bus.reg1WritebackAddress_i = addr;
    bus.reg1WritebackVal_i     = val;
    bus.reg2WritebackEnable_i  = cr;
    bus.caUpdate_i             = ca;
    bus.reg2WritebackVal_i     = {62'd0, carry};
  endtask

  task automatic idle();
    bus.enable_i = 1'b0;
  endtask

  task automatic expect_gpr(input logic [4:0] addr, input logic [63:0] val);
    gpr_exp_t e;
    e.addr = addr;
    e.val  = val;
    gq.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((gq.size() != 0 || cq.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    tests_run++;
    if (gq.size() != 0 || cq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d gpr and %0d cr writes outstanding, expected 0",
               gq.size(), cq.size());
      gq.delete();
      cq.delete();
    end
    repeat (2) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, 64'(bus.regFileWriteEnable_o), 64'd0);
    check({tag, "_addr"}, 64'(bus.regFileWriteAddress_o), 64'd0);
    check({tag, "_val"}, bus.regFileWriteVal_o, 64'd0);
    check({tag, "_crwen"}, 64'(bus.crWriteEnable_o), 64'd0);
    check({tag, "_cr0"}, 64'(bus.cr0_o), 64'd0);
    check({tag, "_ca"}, 64'(bus.xerCA_o), 64'd0);
    check({tag, "_ca32"}, 64'(bus.xerCA32_o), 64'd0);
    check({tag, "_so"}, 64'(bus.xerSO_o), 64'd0);
    check({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
    check({tag, "_overflow"}, 64'(bus.overflow_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // en unit is64 wr addr value cr ca carry | cr0 ca ca32 accepted
    vecs[0]  = '{1'b1, 3'd0, 1'b0, 1'b1, 5'd3,  64'h10,                  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 3'd0, 1'b1, 1'b1, 5'd4,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 3'd0, 1'b0, 1'b1, 5'd5,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd0, 1'b1, 1'b1, 5'd6,  64'h0,                   1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 3'd0, 1'b1, 1'b0, 5'd0,  64'h0000_0000_8000_0000, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 3'd0, 1'b0, 1'b0, 5'd0,  64'h0000_0000_8000_0000, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'd0, 1'b0, 1'b1, 5'd7,  64'h55,                  1'b0, 1'b1, 2'd1, 4'b1000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 3'd1, 1'b0, 1'b1, 5'd8,  64'h66,                  1'b1, 1'b1, 2'd2, 4'b1000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd0, 1'b0, 1'b0, 5'd9,  64'h77,                  1'b0, 1'b0, 2'd2, 4'b1000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'd0, 1'b0, 1'b0, 5'd0,  64'h0,                   1'b0, 1'b1, 2'd2, 4'b1000, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 1'b0, 1'b1, 5'd10, 64'hAA,                  1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 3'd0, 1'b0, 1'b1, 5'd31, 64'h7FFF_FFFF,           1'b1, 1'b1, 2'd3, 4'b0100, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 3'd0, 1'b0, 1'b0, 5'd0,  64'h0000_0001_0000_0000, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 1'b1};

    reset_i = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 2'd0);
    bus.regFileReady_i = 1'b1;
    repeat (2) cycle();
    check_all_zero("reset");
    reset_i = 1'b1;
    cycle();

    // Single-entry vectors; CR0/XER are held state, so expectations accumulate down the table
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].unit, vecs[i].is64, vecs[i].wr, vecs[i].addr, vecs[i].val,
            vecs[i].cr, vecs[i].ca, vecs[i].carry);
      bus.regFileReady_i = 1'b1;
      if (vecs[i].acc && vecs[i].wr) expect_gpr(vecs[i].addr, vecs[i].val);
      if (vecs[i].acc && vecs[i].cr) cq.push_back(vecs[i].exp_cr0);
      cycle();
      idle();
      repeat (3) cycle();
      check($sformatf("vec%0d_cr0", i), 64'(bus.cr0_o), 64'(vecs[i].exp_cr0));
      check($sformatf("vec%0d_ca", i), 64'(bus.xerCA_o), 64'(vecs[i].exp_ca));
      check($sformatf("vec%0d_ca32", i), 64'(bus.xerCA32_o), 64'(vecs[i].exp_ca32));
      check($sformatf("vec%0d_so", i), 64'(bus.xerSO_o), 64'd0);
    end
    check("vec_outstanding", 64'(gq.size() + cq.size()), 64'd0);

    // One-cycle latency, no bypass, single-cycle pulse
    drive(1'b1, 3'd0, 1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 1'b0, 2'd0);
    expect_gpr(5'd9, 64'h99);
    cycle();
    check("no_bypass_wen", 64'(bus.regFileWriteEnable_o), 64'd0);
    idle();
    cycle();
    check("latency_wen", 64'(bus.regFileWriteEnable_o), 64'd1);
    check("latency_addr", 64'(bus.regFileWriteAddress_o), 64'd9);
    check("latency_crwen", 64'(bus.crWriteEnable_o), 64'd0);
    cycle();
    check("pulse_wen", 64'(bus.regFileWriteEnable_o), 64'd0);

    // Fill with the port blocked, overflow on the fifth, then four back-to-back writes
    bus.regFileReady_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'd0, 1'b1, 1'b1, 5'(10 + k), 64'h1000 + 64'(k), 1'b0, 1'b0, 2'd0);
      if (k < 4) expect_gpr(5'(10 + k), 64'h1000 + 64'(k));
      cycle();
      check($sformatf("fill%0d_stall", k), 64'(bus.stall_o), (k >= 3) ? 64'd1 : 64'd0);
      check($sformatf("fill%0d_hold_wen", k), 64'(bus.regFileWriteEnable_o), 64'd0);
    end
    check("fill_overflow", 64'(bus.overflow_o), 64'd1);
    idle();
    cycle();
    check("blocked_wen", 64'(bus.regFileWriteEnable_o), 64'd0);
    bus.regFileReady_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("burst%0d_wen", k), 64'(bus.regFileWriteEnable_o), 64'd1);
    end
    cycle();
    check("burst_end_wen", 64'(bus.regFileWriteEnable_o), 64'd0);
    check("burst_stall", 64'(bus.stall_o), 64'd0);
    check("overflow_sticky", 64'(bus.overflow_o), 64'd1);
    check("burst_outstanding", 64'(gq.size()), 64'd0);

    // Push while full and the head retires in the same cycle: still dropped
    reset_i = 1'b0;
    cycle();
    reset_i = 1'b1;
    check("rst2_overflow", 64'(bus.overflow_o), 64'd0);
    bus.regFileReady_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd0, 1'b1, 1'b1, 5'(16 + k), 64'h2000 + 64'(k), 1'b0, 1'b0, 2'd0);
      expect_gpr(5'(16 + k), 64'h2000 + 64'(k));
      cycle();
    end
    bus.regFileReady_i = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 1'b1, 5'd20, 64'h2004, 1'b0, 1'b0, 2'd0);
    cycle();
    check("full_retire_overflow", 64'(bus.overflow_o), 64'd1);
    idle();
    drain(20);

    // Push every cycle with ready toggling; order preserved, never full
    for (int k = 0; k < 4; k++) begin
      bus.regFileReady_i = (k % 2 == 0);
      drive(1'b1, 3'd0, 1'b1, 1'b1, 5'(21 + k), 64'h3000 + 64'(k), 1'b0, 1'b0, 2'd0);
      expect_gpr(5'(21 + k), 64'h3000 + 64'(k));
      cycle();
      check($sformatf("toggle%0d_stall", k), 64'(bus.stall_o), 64'd0);
    end
    idle();
    bus.regFileReady_i = 1'b1;
    drain(20);

    // Set CR0/XER state, queue three blocked writes, then reset mid-drain
    drive(1'b1, 3'd0, 1'b1, 1'b0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 2'd3);
    cq.push_back(4'b1000);
    cycle();
    idle();
    drain(10);
    check("prereset_ca", 64'(bus.xerCA_o), 64'd1);
    bus.regFileReady_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 1'b1, 1'b1, 5'(25 + k), 64'h4000 + 64'(k), 1'b0, 1'b0, 2'd0);
      cycle();
    end
    reset_i = 1'b0;
    bus.regFileReady_i = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 1'b1, 5'd30, 64'h5000, 1'b1, 1'b1, 2'd3);
    cycle();
    check_all_zero("midreset");
    reset_i = 1'b1;
    idle();
    repeat (6) cycle();
    check("postreset_wen", 64'(bus.regFileWriteEnable_o), 64'd0);
    check("postreset_cr0", 64'(bus.cr0_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
